// File: rtl/pwm_ctrl.sv
// PWM timebase controller: prescaled up-counter with shadowed period/compare/function
// registers that take effect only at a counter wrap, or immediately when the block is idle.
module pwm_ctrl #(
    parameter int unsigned PSC_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             cnt_clr,
    input  logic [PSC_W-1:0] prescale,
    input  logic             cfg_wr,
    input  logic [15:0]      cfg_period,
    input  logic [15:0]      cfg_compare1,
    input  logic [15:0]      cfg_compare2,
    input  logic [7:0]       cfg_functions,
    output logic [15:0]      count_val,
    output logic [15:0]      period,
    output logic [15:0]      compare1,
    output logic [15:0]      compare2,
    output logic [7:0]       functions,
    output logic             pwm_en,
    output logic             ovf,
    output logic             cfg_busy,
    output logic             upd_done
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_PEND = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [PSC_W-1:0] r_psc;
    logic [PSC_W-1:0] w_psc_nxt;
    logic [15:0]      w_cnt_nxt;
    logic [15:0]      r_sh_period;
    logic [15:0]      r_sh_cmp1;
    logic [15:0]      r_sh_cmp2;
    logic [7:0]       r_sh_func;
    logic             w_tick;
    logic             w_wrap;
    logic             w_ovf_nxt;
    logic             w_upd_nxt;
    logic             w_ld_cfg;
    logic             w_ld_sh;
    logic             w_cap_sh;

    always_comb begin
        w_state_nxt = r_state;
        w_psc_nxt   = r_psc;
        w_cnt_nxt   = count_val;
        w_ovf_nxt   = 1'b0;
        w_upd_nxt   = 1'b0;
        w_ld_cfg    = 1'b0;
        w_ld_sh     = 1'b0;
        w_cap_sh    = 1'b0;
        w_tick      = (r_state != S_IDLE) && (r_psc == prescale);
        // Only a period-match wrap counts; rolling over 0xFFFF is not a wrap.
        w_wrap      = w_tick && !cnt_clr && (count_val == period);

        case (r_state)
            S_IDLE: begin
                w_cnt_nxt = '0;
                w_psc_nxt = '0;
                if (cfg_wr) begin
                    w_ld_cfg  = 1'b1;
                    w_upd_nxt = 1'b1;
                end else if (en) begin
                    w_state_nxt = S_RUN;
                end
            end
            default: begin
                if (!en) begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = '0;
                    w_psc_nxt   = '0;
                    if (cfg_wr) begin
                        w_ld_cfg  = 1'b1;
                        w_upd_nxt = 1'b1;
                    end else if (r_state == S_PEND) begin
                        w_ld_sh   = 1'b1;
                        w_upd_nxt = 1'b1;
                    end
                end else begin
                    if (cnt_clr) begin
                        w_cnt_nxt = '0;
                        w_psc_nxt = '0;
                    end else if (w_tick) begin
                        w_psc_nxt = '0;
                        if (w_wrap) begin
                            w_cnt_nxt = '0;
                            w_ovf_nxt = 1'b1;
                        end else begin
                            w_cnt_nxt = count_val + 16'd1;
                        end
                    end else begin
                        w_psc_nxt = r_psc + 1'b1;
                    end

                    if ((r_state == S_PEND) && w_wrap) begin
                        w_ld_sh     = 1'b1;
                        w_upd_nxt   = 1'b1;
                        w_state_nxt = S_RUN;
                    end
                    // A write coinciding with the wrap lands in shadow and keeps us pending.
                    if (cfg_wr) begin
                        w_cap_sh    = 1'b1;
                        w_state_nxt = S_PEND;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_psc       <= '0;
            count_val   <= '0;
            period      <= '0;
            compare1    <= '0;
            compare2    <= '0;
            functions   <= '0;
            r_sh_period <= '0;
            r_sh_cmp1   <= '0;
            r_sh_cmp2   <= '0;
            r_sh_func   <= '0;
            pwm_en      <= 1'b0;
            ovf         <= 1'b0;
            cfg_busy    <= 1'b0;
            upd_done    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_psc     <= w_psc_nxt;
            count_val <= w_cnt_nxt;
            ovf       <= w_ovf_nxt;
            upd_done  <= w_upd_nxt;
            pwm_en    <= (w_state_nxt != S_IDLE);
            cfg_busy  <= (w_state_nxt == S_PEND);
            if (w_ld_cfg) begin
                period    <= cfg_period;
                compare1  <= cfg_compare1;
                compare2  <= cfg_compare2;
                functions <= cfg_functions;
            end else if (w_ld_sh) begin
                period    <= r_sh_period;
                compare1  <= r_sh_cmp1;
                compare2  <= r_sh_cmp2;
                functions <= r_sh_func;
            end
            if (w_cap_sh) begin
                r_sh_period <= cfg_period;
                r_sh_cmp1   <= cfg_compare1;
                r_sh_cmp2   <= cfg_compare2;
                r_sh_func   <= cfg_functions;
            end
        end
    end

endmodule
